// File: rtl/qoi_types_pkg.sv
// rtl/qoi_types_pkg.sv - shared QOI pixel/index types, op tags and decoder state encoding.
package qoi_types;

    localparam int QOI_SIZE_W = 30;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef logic [5:0]            index_t;
    typedef logic [QOI_SIZE_W-1:0] size_t;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_FETCH,
        DEC_ARGS,
        DEC_EMIT,
        DEC_DONE
    } qoi_dec_state_t;

    localparam logic [1:0] TAG_INDEX = 2'b00;
    localparam logic [1:0] TAG_DIFF  = 2'b01;
    localparam logic [1:0] TAG_LUMA  = 2'b10;
    localparam logic [1:0] TAG_RUN   = 2'b11;
    localparam logic [7:0] OP_RGB    = 8'hFE;
    localparam logic [7:0] OP_RGBA   = 8'hFF;

    // The full-byte RGB/RGBA ops share the RUN tag, so they must be tested first.
    function automatic logic [2:0] arg_need(input logic [7:0] op);
        if (op == OP_RGBA)
            return 3'd4;
        else if (op == OP_RGB)
            return 3'd3;
        else if (op[7:6] == TAG_LUMA)
            return 3'd1;
        else
            return 3'd0;
    endfunction

    function automatic index_t qoi_hash(input pixel_t p);
        logic [12:0] h;
        h = {5'd0, p.r} * 13'd3 + {5'd0, p.g} * 13'd5
          + {5'd0, p.b} * 13'd7 + {5'd0, p.a} * 13'd11;
        return h[5:0];
    endfunction

endpackage

// File: rtl/qoi_pixel_alu.sv
// rtl/qoi_pixel_alu.sv - combinational QOI op evaluation: new pixel from op, args, prev and index entry.
module qoi_pixel_alu
    import qoi_types::*;
(
    input  logic [7:0]  op_i,
    input  logic [31:0] args_i,
    input  pixel_t      prev_i,
    input  pixel_t      idx_px_i,
    output pixel_t      px_o,
    output index_t      hash_o
);

    logic [7:0] dg;

    always_comb begin
        px_o = prev_i;
        dg   = {2'b00, op_i[5:0]} - 8'd32;
        if (op_i == OP_RGBA) begin
            px_o = args_i;
        end else if (op_i == OP_RGB) begin
            px_o = {prev_i.a, args_i[23:0]};
        end else begin
            case (op_i[7:6])
                TAG_INDEX: px_o = idx_px_i;
                TAG_DIFF: begin
                    px_o.r = prev_i.r + {6'd0, op_i[5:4]} - 8'd2;
                    px_o.g = prev_i.g + {6'd0, op_i[3:2]} - 8'd2;
                    px_o.b = prev_i.b + {6'd0, op_i[1:0]} - 8'd2;
                end
                TAG_LUMA: begin
                    px_o.r = prev_i.r + dg + {4'd0, args_i[7:4]} - 8'd8;
                    px_o.g = prev_i.g + dg;
                    px_o.b = prev_i.b + dg + {4'd0, args_i[3:0]} - 8'd8;
                end
                default: px_o = prev_i;
            endcase
        end
    end

    assign hash_o = qoi_hash(px_o);

endmodule

// File: rtl/qoi_decoder.sv
// rtl/qoi_decoder.sv - streaming QOI op-byte to RGBA pixel decoder with internal index and prev pixel.
module qoi_decoder
    import qoi_types::*;
#(
    parameter int SIZE_W = QOI_SIZE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              px_valid,
    output logic [31:0]       px_data,
    input  logic              px_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SIZE_W-1:0] count
);

    localparam pixel_t PIX_INIT = 32'hFF00_0000;

    qoi_dec_state_t    state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] count_q, count_d, count_inc;
    pixel_t            prev_q, prev_d;
    pixel_t            px_q, px_d;
    logic [5:0]        run_left_q, run_left_d;
    logic [7:0]        op_q, op_d;
    logic [31:0]       args_q, args_d;
    logic [2:0]        arg_cnt_q, arg_cnt_d;
    logic              err_q, err_d;

    pixel_t            index_q [64];
    logic              index_clr, index_we, load_px;

    logic [7:0]        alu_op;
    logic [31:0]       alu_args;
    pixel_t            alu_px;
    index_t            alu_hash;

    qoi_pixel_alu u_alu (
        .op_i     (alu_op),
        .args_i   (alu_args),
        .prev_i   (prev_q),
        .idx_px_i (index_q[in_data[5:0]]),
        .px_o     (alu_px),
        .hash_o   (alu_hash)
    );

    assign count_inc = count_q + {{(SIZE_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        count_d    = count_q;
        prev_d     = prev_q;
        px_d       = px_q;
        run_left_d = run_left_q;
        op_d       = op_q;
        args_d     = args_q;
        arg_cnt_d  = arg_cnt_q;
        err_d      = err_q;
        index_clr  = 1'b0;
        index_we   = 1'b0;
        load_px    = 1'b0;
        alu_op     = (state_q == DEC_FETCH) ? in_data : op_q;
        alu_args   = args_q;
        // The byte on the bus is merged so the final argument decodes in its accept cycle.
        alu_args[{arg_cnt_q[1:0], 3'b000} +: 8] = in_data;

        case (state_q)
            DEC_IDLE, DEC_DONE: begin
                if (start) begin
                    size_d     = size;
                    count_d    = '0;
                    prev_d     = PIX_INIT;
                    err_d      = 1'b0;
                    run_left_d = '0;
                    index_clr  = 1'b1;
                    state_d    = (size == '0) ? DEC_DONE : DEC_FETCH;
                end
            end
            DEC_FETCH: begin
                if (in_valid) begin
                    op_d      = in_data;
                    arg_cnt_d = '0;
                    if (arg_need(in_data) == 3'd0) begin
                        load_px    = 1'b1;
                        run_left_d = (in_data[7:6] == TAG_RUN) ? in_data[5:0] : 6'd0;
                    end else begin
                        state_d = DEC_ARGS;
                    end
                end
            end
            DEC_ARGS: begin
                if (in_valid) begin
                    args_d    = alu_args;
                    arg_cnt_d = arg_cnt_q + 3'd1;
                    if (arg_cnt_q + 3'd1 == arg_need(op_q)) begin
                        load_px    = 1'b1;
                        run_left_d = '0;
                    end
                end
            end
            DEC_EMIT: begin
                if (px_ready) begin
                    count_d = count_inc;
                    if (count_inc == size_q) begin
                        state_d = DEC_DONE;
                        err_d   = (run_left_q != '0);
                    end else if (run_left_q != '0) begin
                        run_left_d = run_left_q - 6'd1;
                    end else begin
                        state_d = DEC_FETCH;
                    end
                end
            end
            default: state_d = DEC_IDLE;
        endcase

        if (load_px) begin
            px_d     = alu_px;
            prev_d   = alu_px;
            index_we = 1'b1;
            state_d  = DEC_EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DEC_IDLE;
            size_q     <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            px_q       <= '0;
            run_left_q <= '0;
            op_q       <= '0;
            args_q     <= '0;
            arg_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            count_q    <= count_d;
            prev_q     <= prev_d;
            px_q       <= px_d;
            run_left_q <= run_left_d;
            op_q       <= op_d;
            args_q     <= args_d;
            arg_cnt_q  <= arg_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || index_clr) begin
            for (int i = 0; i < 64; i++) index_q[i] <= '0;
        end else if (index_we) begin
            index_q[alu_hash] <= alu_px;
        end
    end

    assign in_ready = (state_q == DEC_FETCH) || (state_q == DEC_ARGS);
    assign px_valid = (state_q == DEC_EMIT);
    assign px_data  = px_q;
    assign busy     = in_ready || px_valid;
    assign done     = (state_q == DEC_DONE);
    assign err      = err_q;
    assign count    = count_q;

endmodule

// File: tb/tb_qoi_decoder.sv
// tb/tb_qoi_decoder.sv - scoreboard bench for qoi_decoder.
module tb_qoi_decoder;

    localparam int SIZE_W = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SIZE_W-1:0] size = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              px_valid;
    logic [31:0]       px_data;
    logic              px_ready = 1'b1;
    logic              busy, done, err;
    logic [SIZE_W-1:0] count;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic [31:0] sb[$];
    int unsigned hs_cyc[$];
    logic [31:0] hold_px;

    qoi_decoder #(.SIZE_W(SIZE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .size     (size),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .px_valid (px_valid),
        .px_data  (px_data),
        .px_ready (px_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && px_valid && px_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_px", 64'(sb.size()), 64'd1);
            end else begin
                check("px", 64'(px_data), 64'(sb.pop_front()));
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic start_img(input int sz);
        size  = SIZE_W'(sz);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 300) begin
            tick();
            t++;
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_px_valid", 64'(px_valid), 64'd0);
        check("rst_px_data",  64'(px_data),  64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_count",    64'(count),    64'd0);
        rst = 1'b0;
        tick();

        // single RGB pixel
        sb.push_back(32'hFF302010);
        start_img(1);
        check("t1_busy",  64'(busy),  64'd1);
        check("t1_count0", 64'(count), 64'd0);
        send_byte(8'hFE); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        check("t1_latency", 64'(px_valid), 64'd1);
        wait_done();
        check("t1_count", 64'(count), 64'd1);
        check("t1_err",   64'(err),   64'd0);
        check("t1_sb",    64'(sb.size()), 64'd0);

        // RGB, INDEX, DIFF, LUMA, INDEX of a never-written slot
        sb.push_back(32'hFF302010);
        sb.push_back(32'hFF302010);
        sb.push_back(32'hFF312111);
        sb.push_back(32'hFF392919);
        sb.push_back(32'h00000000);
        start_img(5);
        send_byte(8'hFE); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h15);
        send_byte(8'h7F);
        send_byte(8'hA8); send_byte(8'h88);
        send_byte(8'h00);
        wait_done();
        check("t2_count", 64'(count), 64'd5);
        check("t2_err",   64'(err),   64'd0);
        check("t2_sb",    64'(sb.size()), 64'd0);

        // run from the initial prev at one pixel per cycle
        hs_cyc.delete();
        repeat (3) sb.push_back(32'hFF000000);
        start_img(3);
        send_byte(8'hC2);
        check("t3_latency", 64'(px_valid), 64'd1);
        wait_done();
        check("t3_npx",  64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3)
            check("t3_rate", 64'(hs_cyc[2] - hs_cyc[0]), 64'd2);
        check("t3_count", 64'(count), 64'd3);
        check("t3_err",   64'(err),   64'd0);

        // run clipped at size
        sb.push_back(32'hFF030201);
        sb.push_back(32'hFF030201);
        start_img(2);
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hC3);
        wait_done();
        check("t4_count", 64'(count), 64'd2);
        check("t4_err",   64'(err),   64'd1);
        check("t4_sb",    64'(sb.size()), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_in_ready_done", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;

        // backpressure mid-run, with an ignored start while busy
        repeat (4) sb.push_back(32'hFF0C0B0A);
        start_img(4);
        send_byte(8'hFE); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
        send_byte(8'hC2);
        tick();
        px_ready = 1'b0;
        hold_px  = px_data;
        check("t5_cnt_pre", 64'(count), 64'd2);
        size  = SIZE_W'(7);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            check("t5_px_stable", 64'(px_data),  64'(hold_px));
            check("t5_cnt_frozen", 64'(count),   64'd2);
            check("t5_in_ready",  64'(in_ready), 64'd0);
            check("t5_px_valid",  64'(px_valid), 64'd1);
        end
        px_ready = 1'b1;
        wait_done();
        check("t5_count", 64'(count), 64'd4);
        check("t5_err",   64'(err),   64'd0);
        check("t5_sb",    64'(sb.size()), 64'd0);

        // empty image
        start_img(0);
        check("t6_done",  64'(done),  64'd1);
        check("t6_busy",  64'(busy),  64'd0);
        check("t6_count", 64'(count), 64'd0);

        // reset during ARGS, start coincident with reset is dropped
        start_img(1);
        send_byte(8'hFE); send_byte(8'h10);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("t7_in_ready", 64'(in_ready), 64'd0);
        check("t7_px_valid", 64'(px_valid), 64'd0);
        check("t7_px_data",  64'(px_data),  64'd0);
        check("t7_busy",     64'(busy),     64'd0);
        check("t7_done",     64'(done),     64'd0);
        check("t7_err",      64'(err),      64'd0);
        check("t7_count",    64'(count),    64'd0);
        tick();
        check("t7_idle_busy", 64'(busy), 64'd0);
        sb.push_back(32'h04030201);
        start_img(1);
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_done();
        check("t7_count_after", 64'(count), 64'd1);
        check("t7_sb",          64'(sb.size()), 64'd0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
